uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: transmit buffer entries; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_in  input  8  byte to transmit.
REQ-007 SHALL have port data_in_valid  input  1  producer offers data_in.
REQ-008 SHALL have port data_in_ready  output  1  buffer can accept a byte.
REQ-009 SHALL have port serial_out  output  1  UART line; idle high.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes buffered, excluding the frame in flight.
REQ-011 SHALL have port busy  output  1  high while a frame is on the line or the buffer is non-empty.

Function
REQ-012 SHALL define SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division), the number of cycles per bit.
REQ-013 SHALL accept a byte on a rising edge where data_in_valid && data_in_ready, with exactly one push per handshake.
REQ-014 SHALL drive data_in_ready = (fifo_count != FIFO_DEPTH) as a combinational function of registered count.
REQ-015 SHALL ignore data_in while data_in_valid is low or data_in_ready is low, and SHALL neither drop nor duplicate bytes.
REQ-016 SHALL implement the FSM IDLE -> START -> DATA -> [PARITY] -> STOP.
REQ-017 SHALL pop the head byte on the first edge in IDLE where fifo_count > 0; serial_out is low from that edge. A byte pushed at edge N into an empty, idle block goes low at edge N+1.
REQ-018 SHALL hold each bit for exactly SYMBOL_EDGE_TIME cycles, using one bit-period counter and one 3-bit index counter.
REQ-019 SHALL send the frame as: start = 0, data bits 0 to 7 LSB-first, stop = 1.
REQ-020 SHALL, at the end of STOP, go directly to START with a pop if fifo_count > 0, giving back-to-back frames with no idle gap; otherwise it SHALL go to IDLE.
REQ-021 SHALL allow a push and a pop in the same cycle; fifo_count then stays unchanged.
REQ-022 SHALL never push when full; pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL drive serial_out from a register, with no combinational glitches.

Reset
REQ-024 SHALL, on reset assertion, immediately force serial_out = 1, data_in_ready = 0 while reset is held, fifo_count = 0, busy = 0, FSM = IDLE, and all counters and pointers = 0.
REQ-025 SHALL abort any frame in flight and discard buffered bytes on reset; the line returns high without a stop-bit completion.
REQ-026 SHALL assert data_in_ready on the first edge after reset deasserts.

Configuration
REQ-027 SHALL, with UART_TX_PARITY_EN defined, insert an even-parity bit (XOR of the 8 data bits) for SYMBOL_EDGE_TIME cycles between data bit 7 and stop, giving an 11-bit frame.
REQ-028 SHALL, without UART_TX_PARITY_EN, omit the PARITY state, giving a 10-bit frame; no parity logic is synthesized.

Structure
REQ-029 SHALL take the FSM state encodings and the SYMBOL_EDGE_TIME / counter-width calculation from the shared UART constants header/package, also used by the receiver.
REQ-030 SHALL instantiate the buffer as sub-module sync_fifo (parameters WIDTH = 8, DEPTH = FIFO_DEPTH; ports push, pop, full, empty, count).

Verification (CLOCK_FREQ = 1000, BAUD_RATE = 100, so 10 cycles per bit; FIFO_DEPTH = 4)
REQ-031 SHALL verify a single byte: push 0xA5 at edge N -> serial_out low on cycles N+1 to N+10, then 1,0,1,0,0,1,0,1 at 10 cycles each, then stop high for 10 cycles; busy drops at N+101 (with parity: bit 0 inserted, busy drops at N+111).
REQ-032 SHALL verify a burst: push 0x01 to 0x08 with valid held high -> data_in_ready low once fifo_count = 4; all 8 bytes appear in order with no gap between stop and the next start bit.
REQ-033 SHALL verify backpressure: hold valid with 0x3C while ready is low for 50 cycles -> 0x3C is transmitted exactly once after ready rises.
REQ-034 SHALL verify reset mid-frame: assert reset during data bit 3 of 0xF0 with 2 bytes buffered -> serial_out = 1 within the same cycle, fifo_count = 0, and no further frames after release.
REQ-035 SHALL verify parity with UART_TX_PARITY_EN: send 0x07 -> parity bit = 1; send 0x03 -> parity bit = 0.
REQ-036 SHALL verify simultaneous push and pop: push at the stop-to-start edge with fifo_count = 2 -> fifo_count stays 2.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// uart_tx_buffered_pkg: UART constants shared by the transmitter and the receiver.
//   - tx_state_e      : frame FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - DATA_BITS       : payload bits per frame
//   - symbol_edge_time: clock cycles per serial bit (integer CLOCK_FREQ / BAUD_RATE)
//   - bit_cnt_width   : width of a counter that spans one bit period
package uart_tx_buffered_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } tx_state_e;

   function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                    input int unsigned baud_rate);
      return clock_freq / baud_rate;
   endfunction

   // A one-cycle bit period still needs a 1-bit counter to stay legal.
   function automatic int unsigned bit_cnt_width(input int unsigned set);
      return (set <= 1) ? 1 : $clog2(set);
   endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count and fall-through head.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset (pointers and count cleared)
//   push, wr_data   : write request and data (ignored while full)
//   pop             : remove the head entry (ignored while empty)
//   rd_data         : current head entry, valid whenever empty is low
//   full, empty     : occupancy flags derived from count
//   count           : number of stored entries, 0..DEPTH
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign full    = (r_count == FULL_CNT);
   assign empty   = (r_count == '0);
   assign count   = r_count;
   assign rd_data = r_mem[r_rd_ptr];
   assign w_push  = push && !full;
   assign w_pop   = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed by a FIFO_DEPTH-entry byte buffer.
// Optional even parity bit between data bit 7 and stop when UART_TX_PARITY_EN is defined
// (11-bit frame); otherwise 10-bit frames with no parity logic.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset (aborts frame, flushes buffer)
//   data_in        : byte to transmit
//   data_in_valid  : producer offers data_in
//   data_in_ready  : buffer can accept a byte (low during reset and while full)
//   serial_out     : registered UART line, idle high
//   fifo_count     : bytes buffered, excluding the frame in flight
//   busy           : frame on the line or buffer non-empty
module uart_tx_buffered
   import uart_tx_buffered_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    data_in,
   input  logic                          data_in_valid,
   output logic                          data_in_ready,
   output logic                          serial_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy
);

   localparam int unsigned SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
   localparam int unsigned CW  = bit_cnt_width(SET);
   localparam logic [CW-1:0] BIT_LAST = CW'(SET - 1);
   localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);
   localparam logic [$clog2(FIFO_DEPTH):0] FULL_CNT = ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH);

   tx_state_e     r_state, w_state_next;
   logic [CW-1:0] r_bit_cnt, w_bit_cnt_next;
   logic [2:0]    r_idx, w_idx_next;
   logic [7:0]    r_shift, w_shift_next;
   logic          r_tx, w_tx_next;
   logic          r_ready_en;
   logic          w_bit_end;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic          w_full;
   logic [7:0]    w_head;
   logic [$clog2(FIFO_DEPTH):0] w_count;
`ifdef UART_TX_PARITY_EN
   logic          r_parity, w_parity_next;
`endif

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (w_push),
      .wr_data (data_in),
      .pop     (w_pop),
      .rd_data (w_head),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_count)
   );

   // r_ready_en keeps ready low while reset is held and until the first edge after release.
   assign data_in_ready = r_ready_en && (w_count != FULL_CNT);
   assign w_push        = data_in_valid && data_in_ready;
   assign fifo_count    = w_count;
   assign serial_out    = r_tx;
   assign busy          = (r_state != StIdle) || !w_empty;
   assign w_bit_end     = (r_bit_cnt == BIT_LAST);

   always_comb begin
      w_state_next   = r_state;
      w_bit_cnt_next = r_bit_cnt;
      w_idx_next     = r_idx;
      w_shift_next   = r_shift;
      w_tx_next      = r_tx;
      w_pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_parity_next  = r_parity;
`endif
      case (r_state)
         StIdle: begin
            w_tx_next = 1'b1;
            if (!w_empty) w_pop = 1'b1;
         end
         StStart: begin
            if (w_bit_end) begin
               w_bit_cnt_next = '0;
               w_idx_next     = '0;
               w_tx_next      = r_shift[0];
               w_state_next   = StData;
            end else begin
               w_bit_cnt_next = r_bit_cnt + 1'b1;
            end
         end
         StData: begin
            if (w_bit_end) begin
               w_bit_cnt_next = '0;
               if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  w_tx_next    = r_parity;
                  w_state_next = StParity;
`else
                  w_tx_next    = 1'b1;
                  w_state_next = StStop;
`endif
               end else begin
                  w_idx_next   = r_idx + 3'd1;
                  w_shift_next = r_shift >> 1;
                  w_tx_next    = r_shift[1];
               end
            end else begin
               w_bit_cnt_next = r_bit_cnt + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (w_bit_end) begin
               w_bit_cnt_next = '0;
               w_tx_next      = 1'b1;
               w_state_next   = StStop;
            end else begin
               w_bit_cnt_next = r_bit_cnt + 1'b1;
            end
         end
`endif
         StStop: begin
            if (w_bit_end) begin
               w_bit_cnt_next = '0;
               // Back-to-back frames: next start bit follows stop with no idle gap.
               if (!w_empty) w_pop = 1'b1;
               else          w_state_next = StIdle;
            end else begin
               w_bit_cnt_next = r_bit_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = StIdle;
            w_tx_next    = 1'b1;
         end
      endcase

      // Every pop launches a frame: latch the head byte and drive the start bit now.
      if (w_pop) begin
         w_shift_next   = w_head;
         w_bit_cnt_next = '0;
         w_idx_next     = '0;
         w_tx_next      = 1'b0;
         w_state_next   = StStart;
`ifdef UART_TX_PARITY_EN
         w_parity_next  = ^w_head;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= StIdle;
         r_bit_cnt  <= '0;
         r_idx      <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
         r_ready_en <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_idx      <= w_idx_next;
         r_shift    <= w_shift_next;
         r_tx       <= w_tx_next;
         r_ready_en <= 1'b1;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_parity <= 1'b0;
      else       r_parity <= w_parity_next;
   end
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: self-checking bench for uart_tx_buffered (10 cycles/bit, depth 4).
// Honours UART_TX_PARITY_EN to expect 11-bit frames.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

   localparam int unsigned CLOCK_FREQ = 1000;
   localparam int unsigned BAUD_RATE  = 100;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int SET = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FL = FRAME_BITS * SET;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       data_in_valid = 1'b0;
   logic       data_in_ready;
   logic       serial_out;
   logic [2:0] fifo_count;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         gap_q[$];
   logic       last_rdy;
   logic [2:0] last_cnt;

   uart_tx_buffered #(
      .CLOCK_FREQ (CLOCK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .serial_out    (serial_out),
      .fifo_count    (fifo_count),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected line level for every cycle of one frame, built from the frame's bit list.
   function automatic logic [FL-1:0] frame_wave(input logic [7:0] b);
      logic [FRAME_BITS-1:0] bits;
      logic [FL-1:0]         w;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
      bits[9] = ^b;
`endif
      bits[FRAME_BITS-1] = 1'b1;
      for (int i = 0; i < FL; i++) w[i] = bits[i / SET];
      return w;
   endfunction

   // One producer cycle: drive at negedge, handshake (if ready) at the following posedge.
   task automatic drive_cycle(input logic v, input logic [7:0] d, output logic acc);
      @(negedge clk);
      data_in_valid = v;
      data_in       = d;
      last_rdy      = data_in_ready;
      last_cnt      = fifo_count;
      acc           = v && data_in_ready;
      @(posedge clk);
      if (acc) exp_q.push_back(d);
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, a);
   endtask

   logic           mon_active = 1'b0;
   int             mon_idx = 0;
   int             idle_run = 0;
   logic [FL-1:0]  mon_obs;
   logic [FL-1:0]  mon_exp;
   logic [7:0]     mon_b;

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((busy !== 1'b0 || mon_active) && n < 5000) begin
         idle(1);
         #1;
         n++;
      end
      check(tag, {31'd0, busy}, 0);
   endtask

   // Line monitor: captures each frame cycle by cycle and compares it to the model frame.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_active = 1'b0;
            idle_run   = 0;
         end else if (!mon_active) begin
            if (serial_out === 1'b0) begin
               gap_q.push_back(idle_run);
               idle_run = 0;
               check("frame_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  mon_b   = exp_q.pop_front();
                  mon_exp = frame_wave(mon_b);
               end else begin
                  mon_b   = 8'h00;
                  mon_exp = '1;
               end
               mon_obs    = '0;
               mon_obs[0] = serial_out;
               mon_idx    = 1;
               mon_active = 1'b1;
            end else begin
               idle_run++;
            end
         end else begin
            mon_obs[mon_idx] = serial_out;
            mon_idx++;
            if (mon_idx == FL) begin
               logic [7:0] dec;
               for (int k = 0; k < 8; k++) dec[k] = mon_obs[(k + 1) * SET + SET / 2];
               rx_q.push_back(dec);
               checks++;
               assert (mon_obs === mon_exp) else begin
                  errors++;
                  $error("FAIL frame_wave byte=%02h observed=%h expected=%h",
                         mon_b, mon_obs, mon_exp);
               end
               mon_active = 1'b0;
            end
         end
      end
   end

   initial begin
      logic       acc;
      logic       saw_full;
      logic [7:0] b;
      int         n0;
      int         lowcnt;
      int         c3c;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_serial", {31'd0, serial_out}, 1);
      check("rst_count", {29'd0, fifo_count}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_ready", {31'd0, data_in_ready}, 0);
      reset = 1'b0;
      idle(1);
      #1;
      check("ready_after_rst", {31'd0, data_in_ready}, 1);

      // Single byte 0xA5: push at edge N, start low from N+1, busy drops at N+FL+1
      idle(2);
      drive_cycle(1'b1, 8'hA5, acc);
      #1;
      check("single_accept", {31'd0, acc}, 1);
      check("single_cnt_n", {29'd0, fifo_count}, 1);
      check("single_line_n", {31'd0, serial_out}, 1);
      check("single_busy_n", {31'd0, busy}, 1);
      idle(1);
      #1;
      check("single_start_n1", {31'd0, serial_out}, 0);
      check("single_cnt_n1", {29'd0, fifo_count}, 0);
      idle(FL - 1);
      #1;
      check("single_busy_last", {31'd0, busy}, 1);
      check("single_stop_last", {31'd0, serial_out}, 1);
      idle(1);
      #1;
      check("single_busy_drop", {31'd0, busy}, 0);

      // Bit after data bit 7: parity under UART_TX_PARITY_EN, stop otherwise
      for (int i = 0; i < 2; i++) begin
         b = (i == 0) ? 8'h07 : 8'h03;
         idle(3);
         drive_cycle(1'b1, b, acc);
         idle(94);
         #1;
`ifdef UART_TX_PARITY_EN
         check("parity_bit", {31'd0, serial_out}, {31'd0, ^b});
`else
         check("stop_bit", {31'd0, serial_out}, 1);
`endif
         drain("parity_drain");
      end

      // Burst 0x01..0x08 with valid held high
      gap_q.delete();
      n0       = rx_q.size();
      saw_full = 1'b0;
      b        = 8'h01;
      for (int cyc = 0; cyc < 1500 && b <= 8'h08; cyc++) begin
         drive_cycle(1'b1, b, acc);
         if (!last_rdy) begin
            saw_full = 1'b1;
            check("burst_full_count", {29'd0, last_cnt}, FIFO_DEPTH);
         end
         if (acc) b++;
      end
      check("burst_all_pushed", {24'd0, b}, 9);
      drain("burst_drain");
      check("burst_saw_full", {31'd0, saw_full}, 1);
      check("burst_frames", rx_q.size() - n0, 8);
      for (int i = 0; i < 8 && n0 + i < rx_q.size(); i++)
         check("burst_order", {24'd0, rx_q[n0 + i]}, i + 1);
      check("burst_gap_entries", 32'(gap_q.size() >= 8), 1);
      for (int i = 1; i < 8 && i < gap_q.size(); i++) check("burst_gap", gap_q[i], 0);

      // Backpressure: hold 0x3C while ready is low
      idle(3);
      n0 = rx_q.size();
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'h3C) b = 8'h3D;
         drive_cycle(1'b1, b, acc);
      end
      lowcnt = 0;
      acc    = 1'b0;
      for (int cyc = 0; cyc < 400 && !acc; cyc++) begin
         drive_cycle(1'b1, 8'h3C, acc);
         if (!acc) lowcnt++;
      end
      check("bp_accepted", {31'd0, acc}, 1);
      check("bp_low_50", 32'(lowcnt >= 50), 1);
      drain("bp_drain");
      c3c = 0;
      for (int i = n0; i < rx_q.size(); i++) if (rx_q[i] == 8'h3C) c3c++;
      check("bp_once", c3c, 1);
      check("bp_frames", rx_q.size() - n0, 6);

      // Push and pop on the same stop-to-start edge with two bytes buffered
      idle(3);
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'($urandom), acc);
      idle(2 * FL - 3);
      #1;
      check("pp_cnt_before", {29'd0, fifo_count}, 2);
      drive_cycle(1'b1, 8'($urandom), acc);
      #1;
      check("pp_accept", {31'd0, acc}, 1);
      check("pp_cnt_after", {29'd0, fifo_count}, 2);
      check("pp_start", {31'd0, serial_out}, 0);
      drain("pp_drain");

      // Reset during data bit 3 of 0xF0 with two bytes buffered
      idle(3);
      drive_cycle(1'b1, 8'hF0, acc);
      drive_cycle(1'b1, 8'($urandom), acc);
      drive_cycle(1'b1, 8'($urandom), acc);
      idle(43);
      #1;
      check("rm_line_before", {31'd0, serial_out}, 0);
      check("rm_cnt_before", {29'd0, fifo_count}, 2);
      n0 = rx_q.size();
      #1;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("rm_line", {31'd0, serial_out}, 1);
      check("rm_cnt", {29'd0, fifo_count}, 0);
      check("rm_busy", {31'd0, busy}, 0);
      check("rm_ready", {31'd0, data_in_ready}, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1);
      #1;
      check("rm_ready_after", {31'd0, data_in_ready}, 1);
      idle(300);
      #1;
      check("rm_no_frames", rx_q.size() - n0, 0);
      check("rm_idle_line", {31'd0, serial_out}, 1);
      check("rm_idle_busy", {31'd0, busy}, 0);

      // Random bytes with random valid gaps
      for (int i = 0; i < 10; i++) begin
         b   = 8'($urandom);
         acc = 1'b0;
         for (int t = 0; t < 600 && !acc; t++) drive_cycle(1'($urandom_range(0, 1)), b, acc);
         check("rand_accept", {31'd0, acc}, 1);
      end
      drain("rand_drain");
      check("model_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
